el2_trace_capture_fifo: RTL and testbench
=========================================

// Module: el2_trace_capture_fifo
// PURPOSE
//  Multi-channel retire-trace capture buffer. Each cycle it accepts up to NCH
//  trace packets (insn/address/exception/ecause/interrupt/tval per channel) and
//  packs them in channel order into a DEPTH-entry FIFO. A debug/trace sink
//  drains the FIFO through a single valid/ready port.
//  Sits between the core retire trace outputs and the SoC trace port/DMI.
//  Successor to the single-channel, unbuffered trace packet: adds channel count,
//  buffering, loss accounting and flush.
// PARAMETERS
//  NCH    1   retire channels, 1..4
//  DEPTH  8   FIFO entries, power of 2, >= NCH
//  CW     16  width of the saturating drop counter
// PORTS
//  clk            in   1          core clock
//  rst            in   1          asynchronous reset, active-high
//  en             in   1          capture enable; 0 = inputs ignored, not counted as drops
//  flush          in   1          synchronous clear of FIFO, lost flag and drop counter
//  tr_valid       in   NCH        per-channel packet valid
//  tr_insn        in   NCH*32     instruction, channel c at [32c+:32]
//  tr_address     in   NCH*32     PC
//  tr_exception   in   NCH        exception flag
//  tr_ecause      in   NCH*5      exception cause
//  tr_interrupt   in   NCH        interrupt flag
//  tr_tval        in   NCH*32     trap value
//  out_valid      out  1          head entry available
//  out_ready      in   1          sink accepts head
//  out_insn       out  32         head fields, same meaning as inputs
//  out_address    out  32
//  out_exception  out  1
//  out_ecause     out  5
//  out_interrupt  out  1
//  out_tval       out  32
//  out_ch         out  max(1,$clog2(NCH))  source channel of head entry
//  out_lost       out  1          one or more packets were dropped before this one
//  count          out  $clog2(DEPTH)+1     occupied entries
//  drop_cnt       out  CW         dropped packets, saturates at all-ones
// BEHAVIOUR
//  - Reset: pointers=0, count=0, out_valid=0, lost_pending=0, drop_cnt=0.
//    Head data outputs read storage and are don't-care while out_valid=0.
//  - Storage is flop array; out_* is a combinational read at rd_ptr.
//    out_valid = (count != 0).
//  - Latency: a packet pushed in cycle N appears at the output in cycle N+1.
//  - Pop: out_valid & out_ready at the clock edge advances rd_ptr.
//    out_* stable while out_valid & !out_ready.
//  - Push: only when en=1. Requesting channels are taken in ascending index order.
//    free = DEPTH - count, sampled before this cycle's pop; a same-cycle pop does
//    not create room for a same-cycle push.
//    The first min(free, #valid) requesters are written at wr_ptr, wr_ptr+1, ...;
//    the remaining requesters are dropped.
//  - Drops: drop_cnt += #dropped (saturating at 2^CW-1). Any drop sets
//    lost_pending. Only the first entry pushed in a later cycle is stored with
//    lost=1, which clears lost_pending. Entries pushed in the same cycle as a
//    drop are older than the dropped packets, so they carry lost=0.
//  - Pointers wrap modulo DEPTH. count_next = count + pushed - popped, which
//    never exceeds DEPTH.
//  - Flush has priority over push and pop in the same cycle: the result is
//    count=0, pointers=0, lost_pending=0, drop_cnt=0, and that cycle's inputs
//    are discarded and not counted.
//  - Asynchronous reset mid-operation: immediate return to reset state. No
//    partial entry survives.
// TESTING
//  - Reset: assert rst mid-burst -> out_valid=0, count=0, drop_cnt=0 without
//    waiting for a clock edge.
//  - NCH=2, DEPTH=8, out_ready=0, both channels valid for 4 cycles
//    (insn=ch<<8|cyc) -> count=8, drop_cnt=0. Drain order: ch0c0, ch1c0,
//    ch0c1, ..., each one cycle after its push.
//  - Same setup, 5th cycle both valid -> 2 drops, drop_cnt=2. Drain 1, then push
//    ch0 only -> that entry has out_lost=1. A following push has out_lost=0.
//  - count=7, tr_valid=2'b11 with simultaneous pop -> ch0 stored, ch1 dropped,
//    count=7, drop_cnt +1.
//  - flush with tr_valid=2'b11 and out_ready=1 in the same cycle -> count=0,
//    drop_cnt=0, nothing stored, next cycle out_valid=0.
//  - CW=2: drop 5 packets -> drop_cnt=3 (saturated).
//    en=0 with tr_valid=1 -> no push, drop_cnt unchanged.

Source files
------------

// File: rtl/el2_trace_capture_fifo.sv
// el2_trace_capture_fifo: packs up to NCH retire-trace packets per cycle into a FIFO drained by one valid/ready port
module el2_trace_capture_fifo #(
   parameter int NCH = 1,
   parameter int DEPTH = 8,
   parameter int CW = 16,
   localparam int AW = $clog2(DEPTH),
   localparam int CHW = NCH > 1 ? $clog2(NCH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              flush,
   input  logic [NCH-1:0]    tr_valid,
   input  logic [NCH*32-1:0] tr_insn,
   input  logic [NCH*32-1:0] tr_address,
   input  logic [NCH-1:0]    tr_exception,
   input  logic [NCH*5-1:0]  tr_ecause,
   input  logic [NCH-1:0]    tr_interrupt,
   input  logic [NCH*32-1:0] tr_tval,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_insn,
   output logic [31:0]       out_address,
   output logic              out_exception,
   output logic [4:0]        out_ecause,
   output logic              out_interrupt,
   output logic [31:0]       out_tval,
   output logic [CHW-1:0]    out_ch,
   output logic              out_lost,
   output logic [AW:0]       count,
   output logic [CW-1:0]     drop_cnt
);
   logic [31:0]      insn_q    [DEPTH];
   logic [31:0]      address_q [DEPTH];
   logic [31:0]      tval_q    [DEPTH];
   logic [4:0]       ecause_q  [DEPTH];
   logic [CHW-1:0]   ch_q      [DEPTH];
   logic [DEPTH-1:0] exc_q, intr_q, lost_q;
   logic [AW-1:0]    rd_ptr, wr_ptr;
   logic [AW-1:0]    slot [NCH];
   logic [NCH-1:0]   acc, first;
   logic [AW:0]      free, n;
   logic [2:0]       nd;
   logic [CW+2:0]    sum;
   logic             lost_pending, pop;

   assign out_valid     = count != '0;
   assign pop           = out_valid & out_ready;
   assign free          = (AW+1)'(DEPTH) - count;
   assign out_insn      = insn_q[rd_ptr];
   assign out_address   = address_q[rd_ptr];
   assign out_tval      = tval_q[rd_ptr];
   assign out_ecause    = ecause_q[rd_ptr];
   assign out_ch        = ch_q[rd_ptr];
   assign out_exception = exc_q[rd_ptr];
   assign out_interrupt = intr_q[rd_ptr];
   assign out_lost      = lost_q[rd_ptr];

   // free is taken before this cycle's pop, so a pop never makes room for a same-cycle push
   always_comb begin
      n = '0;
      nd = '0;
      acc = '0;
      first = '0;
      for (int c = 0; c < NCH; c++) begin
         slot[c] = wr_ptr + n[AW-1:0];
         if (en && tr_valid[c]) begin
            if (n < free) begin
               acc[c] = 1'b1;
               first[c] = (n == '0) & lost_pending;
               n = n + (AW+1)'(1);
            end else
               nd = nd + 3'(1);
         end
      end
      sum = {3'b0, drop_cnt} + {{CW{1'b0}}, nd};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count <= '0;
         lost_pending <= 1'b0;
         drop_cnt <= '0;
      end else begin
         rd_ptr <= rd_ptr + AW'(pop);
         wr_ptr <= wr_ptr + n[AW-1:0];
         count <= count + n - (AW+1)'(pop);
         lost_pending <= nd != '0 ? 1'b1 : n != '0 ? 1'b0 : lost_pending;
         drop_cnt <= sum > {3'b0, {CW{1'b1}}} ? '1 : sum[CW-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!flush)
         for (int c = 0; c < NCH; c++)
            if (acc[c]) begin
               insn_q[slot[c]] <= tr_insn[32*c +: 32];
               address_q[slot[c]] <= tr_address[32*c +: 32];
               tval_q[slot[c]] <= tr_tval[32*c +: 32];
               ecause_q[slot[c]] <= tr_ecause[5*c +: 5];
               ch_q[slot[c]] <= CHW'(c);
               exc_q[slot[c]] <= tr_exception[c];
               intr_q[slot[c]] <= tr_interrupt[c];
               lost_q[slot[c]] <= first[c];
            end
   end
endmodule

// File: tb/tb_el2_trace_capture_fifo.sv
// tb_el2_trace_capture_fifo: queue-model checked bench for a 2-channel, 8-deep capture FIFO (16-bit and 2-bit drop counters)
module tb_el2_trace_capture_fifo;
   logic        clk = 0, rst, en, flush, out_ready;
   logic [1:0]  tr_valid, tr_exception, tr_interrupt;
   logic [63:0] tr_insn, tr_address, tr_tval;
   logic [9:0]  tr_ecause;
   logic        out_valid, out_exception, out_interrupt, out_ch, out_lost;
   logic [31:0] out_insn, out_address, out_tval;
   logic [4:0]  out_ecause;
   logic [3:0]  count;
   logic [15:0] drop_cnt;
   logic        s_valid, s_exception, s_interrupt, s_ch, s_lost;
   logic [31:0] s_insn, s_address, s_tval;
   logic [4:0]  s_ecause;
   logic [3:0]  s_count;
   logic [1:0]  s_drop_cnt;
   int total = 0, bad = 0;

   always #5 clk = ~clk;

   el2_trace_capture_fifo #(.NCH(2), .DEPTH(8), .CW(16)) dut (
      .clk(clk), .rst(rst), .en(en), .flush(flush), .tr_valid(tr_valid), .tr_insn(tr_insn),
      .tr_address(tr_address), .tr_exception(tr_exception), .tr_ecause(tr_ecause),
      .tr_interrupt(tr_interrupt), .tr_tval(tr_tval), .out_valid(out_valid), .out_ready(out_ready),
      .out_insn(out_insn), .out_address(out_address), .out_exception(out_exception),
      .out_ecause(out_ecause), .out_interrupt(out_interrupt), .out_tval(out_tval), .out_ch(out_ch),
      .out_lost(out_lost), .count(count), .drop_cnt(drop_cnt));

   el2_trace_capture_fifo #(.NCH(2), .DEPTH(8), .CW(2)) dut_s (
      .clk(clk), .rst(rst), .en(en), .flush(flush), .tr_valid(tr_valid), .tr_insn(tr_insn),
      .tr_address(tr_address), .tr_exception(tr_exception), .tr_ecause(tr_ecause),
      .tr_interrupt(tr_interrupt), .tr_tval(tr_tval), .out_valid(s_valid), .out_ready(out_ready),
      .out_insn(s_insn), .out_address(s_address), .out_exception(s_exception),
      .out_ecause(s_ecause), .out_interrupt(s_interrupt), .out_tval(s_tval), .out_ch(s_ch),
      .out_lost(s_lost), .count(s_count), .drop_cnt(s_drop_cnt));

   typedef struct {
      logic [31:0] insn, address, tval;
      logic [4:0]  ecause;
      logic        exc, intr, ch, lost;
   } ent_t;
   ent_t q[$];
   ent_t m_e;
   bit   lp;
   int   d16, d2, m_free, m_taken, m_drop;
   bit   m_pop;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, act, exp);
      end
   endtask

   // reference: an ordered list of stored packets, filled from the inputs by the capture rules
   always @(posedge clk or posedge rst) begin
      if (rst || flush) begin
         q.delete();
         lp = 0;
         d16 = 0;
         d2 = 0;
      end else begin
         m_pop = q.size() != 0 && out_ready;
         m_free = 8 - q.size();
         m_taken = 0;
         m_drop = 0;
         if (en)
            for (int c = 0; c < 2; c++)
               if (tr_valid[c]) begin
                  if (m_taken < m_free) begin
                     m_e.insn = tr_insn[32*c +: 32];
                     m_e.address = tr_address[32*c +: 32];
                     m_e.tval = tr_tval[32*c +: 32];
                     m_e.ecause = tr_ecause[5*c +: 5];
                     m_e.exc = tr_exception[c];
                     m_e.intr = tr_interrupt[c];
                     m_e.ch = c[0];
                     m_e.lost = m_taken == 0 && lp;
                     q.push_back(m_e);
                     m_taken++;
                  end else
                     m_drop++;
               end
         if (m_pop) void'(q.pop_front());
         if (m_drop != 0) lp = 1;
         else if (m_taken != 0) lp = 0;
         d16 = d16 + m_drop > 65535 ? 65535 : d16 + m_drop;
         d2 = d2 + m_drop > 3 ? 3 : d2 + m_drop;
      end
   end

   always @(negedge clk) begin
      chk("count", count, q.size());
      chk("count_s", s_count, q.size());
      chk("out_valid", out_valid, q.size() != 0);
      chk("drop_cnt", drop_cnt, d16);
      chk("drop_cnt_s", s_drop_cnt, d2);
      if (q.size() != 0) begin
         chk("insn", out_insn, q[0].insn);
         chk("address", out_address, q[0].address);
         chk("tval", out_tval, q[0].tval);
         chk("ecause", out_ecause, q[0].ecause);
         chk("exception", out_exception, q[0].exc);
         chk("interrupt", out_interrupt, q[0].intr);
         chk("ch", out_ch, q[0].ch);
         chk("lost", out_lost, q[0].lost);
         chk("lost_s", s_lost, q[0].lost);
      end
   end

   task automatic drive(input logic [1:0] v, input int k, input logic rdy, input logic e, input logic f);
      for (int c = 0; c < 2; c++) begin
         logic [31:0] ins;
         ins = (32'(c) << 8) | 32'(k);
         tr_insn[32*c +: 32] = ins;
         tr_address[32*c +: 32] = 32'h8000_0000 + (ins << 2);
         tr_tval[32*c +: 32] = ~ins;
         tr_ecause[5*c +: 5] = ins[4:0] ^ 5'(c);
         tr_exception[c] = ins[0];
         tr_interrupt[c] = ins[1] ^ ins[8];
      end
      tr_valid = v;
      out_ready = rdy;
      en = e;
      flush = f;
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] order [8];
      order = '{32'h100, 32'h001, 32'h101, 32'h002, 32'h102, 32'h003, 32'h103, 32'h005};
      rst = 1;
      tr_valid = 0; tr_insn = 0; tr_address = 0; tr_tval = 0; tr_ecause = 0;
      tr_exception = 0; tr_interrupt = 0; out_ready = 0; en = 0; flush = 0;
      repeat (2) @(negedge clk);
      chk("rst_count", count, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_drop", drop_cnt, 0);
      rst = 0;
      for (int k = 0; k < 4; k++) drive(2'b11, k, 0, 1, 0);
      chk("fill_count", count, 8);
      chk("fill_drop", drop_cnt, 0);
      drive(2'b11, 4, 0, 1, 0);
      chk("full_drop", drop_cnt, 2);
      chk("full_drop_s", s_drop_cnt, 2);
      chk("head0", out_insn, 32'h000);
      drive(2'b00, 0, 1, 1, 0);
      chk("pop1_count", count, 7);
      drive(2'b01, 5, 0, 1, 0);
      chk("refill_count", count, 8);
      for (int i = 0; i < 8; i++) begin
         chk("drain_insn", out_insn, order[i]);
         chk("drain_lost", out_lost, i == 7);
         drive(2'b00, 0, 1, 1, 0);
      end
      chk("drained", out_valid, 0);
      drive(2'b10, 6, 0, 1, 0);
      chk("next_insn", out_insn, 32'h106);
      chk("next_lost", out_lost, 0);
      chk("next_ch", out_ch, 1);
      drive(2'b00, 0, 1, 1, 0);
      for (int k = 7; k < 10; k++) drive(2'b11, k, 0, 1, 0);
      drive(2'b01, 10, 0, 1, 0);
      chk("seven", count, 7);
      drive(2'b11, 11, 1, 1, 0);
      chk("popfull_count", count, 7);
      chk("popfull_drop", drop_cnt, 3);
      drive(2'b11, 12, 0, 1, 0);
      drive(2'b11, 13, 0, 1, 0);
      chk("sat_drop", drop_cnt, 6);
      chk("sat_drop_s", s_drop_cnt, 3);
      drive(2'b11, 14, 1, 0, 0);
      chk("en0_count", count, 7);
      chk("en0_drop", drop_cnt, 6);
      drive(2'b11, 15, 1, 1, 1);
      chk("flush_count", count, 0);
      chk("flush_drop", drop_cnt, 0);
      chk("flush_valid", out_valid, 0);
      drive(2'b00, 0, 1, 1, 0);
      chk("flush_next_valid", out_valid, 0);
      drive(2'b01, 16, 0, 1, 0);
      chk("latency_valid", out_valid, 1);
      chk("latency_insn", out_insn, 32'h010);
      for (int k = 17; k < 22; k++) drive(2'b11, k, 0, 1, 0);
      chk("burst_drop", drop_cnt, 3);
      tr_valid = 0;
      @(posedge clk);
      #2 rst = 1;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_count", count, 0);
      chk("arst_drop", drop_cnt, 0);
      chk("arst_drop_s", s_drop_cnt, 0);
      @(negedge clk);
      rst = 0;
      drive(2'b11, 22, 0, 1, 0);
      drive(2'b00, 0, 1, 1, 0);
      drive(2'b00, 0, 1, 1, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
